// File: rtl/ss_stream_to_binary.sv
// Stochastic-stream decoder: counts ones in a 2^WINDOW_LOG2-sample window and reports the count.
// Latency: 2^WINDOW_LOG2+1 edges from the accepted start edge to the result_valid pulse.
// Backpressure: none; start is ignored while busy, and a new window may begin in the result_valid cycle.
// Build option: define SS_DECODE_BIPOLAR_EN for a signed bipolar result (2*count - 2^WINDOW_LOG2).
module ss_stream_to_binary #(
  parameter int WINDOW_LOG2 = 8,
  parameter int RES_W       = WINDOW_LOG2 + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ss_in,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid
);

  localparam int CW  = WINDOW_LOG2 + 1;
  localparam int WIN = 1 << WINDOW_LOG2;
  // Terminal detection compares against the last index rather than waiting for wrap.
  localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_nxt;
  logic          last;

  // Next-state decode and the running sum including the current sample.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc + CW'(ss_in);
    last      = (state == RUN) && (cnt == LAST_CNT);
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Window accumulation, result capture and the one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt  <= '0;
            acc  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            busy         <= 1'b0;
            result_valid <= 1'b1;
`ifdef SS_DECODE_BIPOLAR_EN
            // 2*count - 2^WINDOW_LOG2 fits exactly in RES_W as two's complement.
            result       <= RES_W'({acc_nxt, 1'b0}) - RES_W'(WIN);
`else
            result       <= RES_W'(acc_nxt);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_stream_to_binary.sv
// Bench for ss_stream_to_binary with a 16-sample window.
// Table of fixed patterns, back-to-back and mid-window reset sequences, then random windows.
// Expected results come from a ones-count model of each pattern.
module tb_ss_stream_to_binary;

  localparam int WL = 4;
  localparam int RW = WL + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ss_in;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_valid;

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] last_res;

  typedef struct {
    logic [15:0]   pat;      // bit k-1 is sample k
    logic [RW-1:0] exp_uni;
    logic [RW-1:0] exp_bip;
  } vec_t;

  vec_t vecs [7];

  ss_stream_to_binary #(.WINDOW_LOG2(WL)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ss_in        (ss_in),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: count the ones, then map to the configured number format.
  function automatic logic [RW-1:0] model(input logic [15:0] pat);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) c += int'(pat[i]);
`ifdef SS_DECODE_BIPOLAR_EN
    return RW'(2 * c - 16);
`else
    return RW'(c);
`endif
  endfunction

  // Run one window. pre_started: start is already high at the current negedge.
  // noisy_start: random start pulses during RUN. hold_start: leave start high in the valid cycle.
  task automatic run_window(input logic [15:0] pat, input logic [RW-1:0] exp,
                            input bit pre_started, input bit noisy_start,
                            input bit hold_start, input string nm);
    int edges;
    int busy_n;
    bit seen;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      ss_in = 1'($urandom_range(0, 1));
    end
    edges  = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        chk({nm, " valid_low_after_start"}, int'(result_valid), 0);
        chk({nm, " result_held"}, int'(result), int'(last_res));
      end
      if (busy) busy_n++;
      if (result_valid) begin
        seen = 1'b1;
      end else begin
        start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
        if (edges <= 16) ss_in = pat[edges-1];
        else             ss_in = 1'($urandom_range(0, 1));
      end
    end
    chk({nm, " latency_edges"}, edges, 17);
    chk({nm, " busy_cycles"}, busy_n, 16);
    chk({nm, " result"}, int'(result), int'(exp));
    last_res = exp;
    start = hold_start;
    if (!hold_start) begin
      @(negedge clk);
      chk({nm, " valid_one_cycle"}, int'(result_valid), 0);
      chk({nm, " result_hold"}, int'(result), int'(exp));
    end
  endtask

  initial begin
    int n_vld;
    int n_busy;
    logic [15:0] pat;

    vecs[0] = '{16'hFFFF, 6'd16, 6'b010000};
    vecs[1] = '{16'h5555, 6'd8,  6'b000000};
    vecs[2] = '{16'h0000, 6'd0,  6'b110000};
    vecs[3] = '{16'h000F, 6'd4,  6'b111000};
    vecs[4] = '{16'h8000, 6'd1,  6'b110010};
    vecs[5] = '{16'h0001, 6'd1,  6'b110010};
    vecs[6] = '{16'h7FFF, 6'd15, 6'b001110};

    rst   = 1'b1;
    start = 1'b0;
    ss_in = 1'b0;
    last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset result", int'(result), 0);
    chk("reset valid", int'(result_valid), 0);

    // Idle with ones on the stream: nothing should be counted or reported.
    rst   = 1'b0;
    ss_in = 1'b1;
    n_vld = 0;
    n_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) n_vld++;
      if (busy) n_busy++;
    end
    chk("idle valid_count", n_vld, 0);
    chk("idle busy_count", n_busy, 0);
    chk("idle result", int'(result), 0);

    foreach (vecs[i]) begin
`ifdef SS_DECODE_BIPOLAR_EN
      run_window(vecs[i].pat, vecs[i].exp_bip, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
`else
      run_window(vecs[i].pat, vecs[i].exp_uni, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));
`endif
    end

    // Stray start pulses during RUN, then a restart in the valid cycle.
    run_window(16'hFFFF, model(16'hFFFF), 1'b0, 1'b1, 1'b1, "b2b_first");
    run_window(16'h5555, model(16'h5555), 1'b1, 1'b0, 1'b0, "b2b_second");

    // Reset after sample 9 of an all-ones window.
    @(negedge clk);
    start = 1'b1;
    ss_in = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      ss_in = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vld = 0;
    n_busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) n_vld++;
      if (busy) n_busy++;
    end
    chk("abort valid_count", n_vld, 0);
    chk("abort busy_count", n_busy, 0);
    chk("abort result", int'(result), 0);
    last_res = '0;
    run_window(16'hFFFF, model(16'hFFFF), 1'b0, 1'b0, 1'b0, "after_abort");

    repeat (20) begin
      pat = 16'($urandom);
      run_window(pat, model(pat), 1'b0, 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
